// File: rtl/board_gpio_pkg.sv
// Shared definitions for the board GPIO AHB-Lite slave: register map, sizes,
// error-response states and the byte-lane helper.
package board_gpio_pkg;

    localparam int N_LED = 6;
    localparam int N_BTN = 5;

    localparam logic [4:0] GPIO_OFS_SOC_ID    = 5'h00;
    localparam logic [4:0] GPIO_OFS_BLD_ID    = 5'h04;
    localparam logic [4:0] GPIO_OFS_CLK_FREQ  = 5'h08;
    localparam logic [4:0] GPIO_OFS_LED       = 5'h0C;
    localparam logic [4:0] GPIO_OFS_BTN_STATE = 5'h10;
    localparam logic [4:0] GPIO_OFS_BTN_IRQEN = 5'h14;
    localparam logic [4:0] GPIO_OFS_BTN_PEND  = 5'h18;
    localparam logic [4:0] GPIO_OFS_ERR       = 5'h1C;

    typedef enum logic [1:0] {RESP_IDLE, RESP_ERR1, RESP_ERR2} gpio_resp_e;

    // Byte lanes touched by a transfer of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            3'd0:    lane_mask = 4'b0001 << addr_lo;
            3'd1:    lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer followed by a stability counter; press_o
// pulses in the same cycle the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] count_q;
    logic             stable_q;
    logic             settle;

    assign settle = (sync_q[1] != stable_q) && (count_q == CNT_LAST);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            count_q  <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] == stable_q) begin
                count_q <= '0;
            end else if (settle) begin
                stable_q <= sync_q[1];
                count_q  <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;
    assign press_o  = settle & sync_q[1];

endmodule

// File: rtl/ahb_lite_board_gpio.sv
// AHB-Lite board I/O slave: ID words, LED register, debounced buttons with
// press-edge pending bits and a registered interrupt line.
module ahb_lite_board_gpio
    import board_gpio_pkg::*;
#(
    parameter logic [31:0] SOC_ID          = 32'h0,
    parameter logic [31:0] BLD_ID          = 32'h0,
    parameter logic [31:0] CORE_CLK_FREQ   = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsel,
    input  logic             hready_in,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [31:0]      haddr,
    input  logic [31:0]      hwdata,
    output logic [31:0]      hrdata,
    output logic             hreadyout,
    output logic             hresp,
    output logic [N_LED-1:0] led_o,
    input  logic [N_BTN-1:0] btn_i,
    output logic             irq_o
);

    gpio_resp_e       resp_state, resp_next;
    logic             addr_accept, addr_err;
    logic [3:0]       lane_sel;
    logic             dp_valid, dp_write, dp_lane0;
    logic [4:0]       dp_ofs;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic [N_LED-1:0] led_q;
    logic [N_BTN-1:0] irqen_q, pend_q, pend_clr;
    logic [N_BTN-1:0] btn_level, btn_state, btn_press;
    logic             irq_q;
    logic             unused_bits;

    assign addr_accept = hsel & hready_in & htrans[1];
    assign addr_err    = ({haddr[4:2], 2'b00} == GPIO_OFS_ERR) || (hsize > 3'd2);
    assign lane_sel    = lane_mask(hsize, haddr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_state <= RESP_IDLE;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_lane0   <= 1'b0;
            dp_ofs     <= '0;
        end else begin
            resp_state <= resp_next;
            dp_valid   <= addr_accept & ~addr_err;
            if (addr_accept) begin
                dp_write <= hwrite;
                dp_lane0 <= lane_sel[0];
                dp_ofs   <= {haddr[4:2], 2'b00};
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        resp_next = resp_state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (resp_state)
            RESP_IDLE: begin
                if (addr_accept && addr_err) resp_next = RESP_ERR1;
            end
            RESP_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                resp_next = RESP_ERR2;
            end
            RESP_ERR2: begin
                hresp     = 1'b1;
                resp_next = (addr_accept && addr_err) ? RESP_ERR1 : RESP_IDLE;
            end
            default: resp_next = RESP_IDLE;
        endcase
    end

    // Every writable field sits in byte lane 0, so only that lane gates a write.
    assign wr_en    = dp_valid & dp_write & dp_lane0;
    assign wr_byte  = hwdata[7:0];
    assign pend_clr = (wr_en && dp_ofs == GPIO_OFS_BTN_PEND) ? wr_byte[N_BTN-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= '0;
            irqen_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_en && dp_ofs == GPIO_OFS_LED)       led_q   <= wr_byte[N_LED-1:0];
            if (wr_en && dp_ofs == GPIO_OFS_BTN_IRQEN) irqen_q <= wr_byte[N_BTN-1:0];
            // A press edge in the same cycle as its W1C keeps the bit set.
            pend_q <= (pend_q & ~pend_clr) | btn_press;
            irq_q  <= |(pend_q & irqen_q);
        end
    end

    always_comb begin
        hrdata = '0;
        if (dp_valid && !dp_write) begin
            case (dp_ofs)
                GPIO_OFS_SOC_ID:    hrdata = SOC_ID;
                GPIO_OFS_BLD_ID:    hrdata = BLD_ID;
                GPIO_OFS_CLK_FREQ:  hrdata = CORE_CLK_FREQ;
                GPIO_OFS_LED:       hrdata = {{(32-N_LED){1'b0}}, led_q};
                GPIO_OFS_BTN_STATE: hrdata = {{(32-N_BTN){1'b0}}, btn_state};
                GPIO_OFS_BTN_IRQEN: hrdata = {{(32-N_BTN){1'b0}}, irqen_q};
                GPIO_OFS_BTN_PEND:  hrdata = {{(32-N_BTN){1'b0}}, pend_q};
                default:            hrdata = '0;
            endcase
        end
    end

    assign btn_level = BTN_ACTIVE_LOW ? ~btn_i : btn_i;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (btn_level[i]),
            .stable_o (btn_state[i]),
            .press_o  (btn_press[i])
        );
    end

    assign led_o       = led_q;
    assign irq_o       = irq_q;
    assign unused_bits = &{1'b0, haddr[31:5], hwdata[31:8], htrans[0], lane_sel[3:1]};

endmodule

// File: tb/tb_ahb_lite_board_gpio.sv
// Self-checking bench for ahb_lite_board_gpio: directed feature tests plus a
// randomized bus/button sequence checked against a register-map model.
module tb_ahb_lite_board_gpio;

    localparam logic [31:0] P_SOC_ID = 32'h5C01_0001;
    localparam logic [31:0] P_BLD_ID = 32'h2024_0611;
    localparam logic [31:0] P_FREQ   = 32'd50_000_000;
    localparam int          DEB      = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel, hready_in, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hreadyout, hresp;
    logic [5:0]  led_o;
    logic [4:0]  btn_i;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    // Register-map model: what software should see at each offset.
    logic [5:0] m_led;
    logic [4:0] m_irqen, m_pend, m_state;

    always #5 clk = ~clk;

    // Single slave on the bus: its own ready is the bus HREADY.
    assign hready_in = hreadyout;

    ahb_lite_board_gpio #(
        .SOC_ID(P_SOC_ID), .BLD_ID(P_BLD_ID), .CORE_CLK_FREQ(P_FREQ),
        .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .hready_in(hready_in), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
        .hreadyout(hreadyout), .hresp(hresp), .led_o(led_o), .btn_i(btn_i), .irq_o(irq_o)
    );

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return P_SOC_ID;
            3'd1:    return P_BLD_ID;
            3'd2:    return P_FREQ;
            3'd3:    return {26'd0, m_led};
            3'd4:    return {27'd0, m_state};
            3'd5:    return {27'd0, m_irqen};
            3'd6:    return {27'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 32'd0;
    endtask

    // One transfer; rd/rdy/rsp are sampled in the first data-phase cycle.
    task automatic bus_xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic rdy, output logic rsp);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = addr;
        @(posedge clk); #1;
        bus_idle();
        hwdata = wd;
        rd = hrdata; rdy = hreadyout; rsp = hresp;
        @(posedge clk); #1;
    endtask

    // Two pipelined word reads, data sampled after each accepting edge.
    task automatic read2(input logic [31:0] a0, input logic [31:0] a1,
                         output logic [31:0] r0, output logic [31:0] r1);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = a0;
        @(posedge clk); #1;
        r0 = hrdata; haddr = a1;
        @(posedge clk); #1;
        bus_idle();
        r1 = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus_idle(); hwdata = 32'd0; btn_i = 5'h1F; rst_n = 1'b0;
        tick(3);
        checks++;
        if ({hreadyout, hresp, hrdata, led_o, irq_o} !== {1'b1, 1'b0, 32'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in: got rdy=%b resp=%b rdata=%h led=%h irq=%b expected 1 0 0 0 0",
                     hreadyout, hresp, hrdata, led_o, irq_o);
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if ({hreadyout, hresp, led_o, irq_o} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_out: got rdy=%b resp=%b led=%h irq=%b expected 1 0 0 0",
                     hreadyout, hresp, led_o, irq_o);
        end
    endtask

    task automatic test_id_regs();
        logic [31:0] rd;
        logic rdy, rsp;
        logic [31:0] exp_id [3];
        exp_id = '{P_SOC_ID, P_BLD_ID, P_FREQ};
        for (int i = 0; i < 3; i++) begin
            bus_xfer(1'b0, 3'd2, 32'(i * 4), 32'd0, rd, rdy, rsp);
            checks++;
            if ({rdy, rsp, rd} !== {1'b1, 1'b0, exp_id[i]}) begin
                errors++;
                $display("FAIL id_read[%0d]: got rdy=%b resp=%b data=%h expected 1 0 %h",
                         i, rdy, rsp, rd, exp_id[i]);
            end
        end
    endtask

    task automatic test_led();
        logic [31:0] rd;
        logic rdy, rsp;
        bus_xfer(1'b1, 3'd2, 32'h0C, 32'hFFFF_FFFF, rd, rdy, rsp);
        checks++;
        if ({rdy, rsp, led_o} !== {1'b1, 1'b0, 6'h3F}) begin
            errors++;
            $display("FAIL led_word_write: got rdy=%b resp=%b led=%h expected 1 0 3f", rdy, rsp, led_o);
        end
        bus_xfer(1'b0, 3'd2, 32'h0C, 32'd0, rd, rdy, rsp);
        checks++;
        if (rd !== 32'h3F) begin
            errors++;
            $display("FAIL led_read: got %h expected 0000003f", rd);
        end
        bus_xfer(1'b1, 3'd0, 32'h0D, 32'h0000_0000, rd, rdy, rsp);
        bus_xfer(1'b0, 3'd2, 32'h0C, 32'd0, rd, rdy, rsp);
        checks++;
        if ({led_o, rd} !== {6'h3F, 32'h3F}) begin
            errors++;
            $display("FAIL led_byte_lane1: got led=%h read=%h expected 3f 0000003f", led_o, rd);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] r0, r1, rd;
        logic rdy, rsp;
        for (int g = 0; g < 3; g++) begin
            btn_i[2] = 1'b0; tick(3);
            btn_i[2] = 1'b1; tick(3);
        end
        tick(DEB + 4);
        read2(32'h10, 32'h18, r0, r1);
        checks++;
        if ({r0, r1} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL glitch_reject: got state=%h pend=%h expected 0 0", r0, r1);
        end
        // Steady press: state must flip exactly 2+DEB edges after the change.
        btn_i[2] = 1'b0;
        tick(DEB);
        read2(32'h10, 32'h10, r0, r1);
        checks++;
        if ({r0, r1} !== {32'd0, 32'h4}) begin
            errors++;
            $display("FAIL press_latency: got edge9=%h edge10=%h expected 0 4", r0, r1);
        end
        read2(32'h18, 32'h14, r0, r1);
        checks++;
        if ({r0, r1, irq_o} !== {32'h4, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL press_pend: got pend=%h irqen=%h irq=%b expected 4 0 0", r0, r1, irq_o);
        end
        bus_xfer(1'b1, 3'd2, 32'h14, 32'h4, rd, rdy, rsp);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_lag: got %b expected 0 in write cycle", irq_o);
        end
        tick(1);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_enable: got %b expected 1", irq_o);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        logic rdy, rsp;
        bus_xfer(1'b1, 3'd2, 32'h18, 32'h4, rd, rdy, rsp);
        tick(1);
        bus_xfer(1'b0, 3'd2, 32'h18, 32'd0, rd, rdy, rsp);
        checks++;
        if ({rd, irq_o} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL w1c_clear: got pend=%h irq=%b expected 0 0", rd, irq_o);
        end
        btn_i[2] = 1'b1;
        tick(DEB + 4);
        bus_xfer(1'b0, 3'd2, 32'h18, 32'd0, rd, rdy, rsp);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL release_no_event: got pend=%h expected 0", rd);
        end
        // Press edge lands on the same edge the W1C is applied.
        btn_i[2] = 1'b0;
        tick(DEB);
        bus_xfer(1'b1, 3'd2, 32'h18, 32'h4, rd, rdy, rsp);
        bus_xfer(1'b0, 3'd2, 32'h18, 32'd0, rd, rdy, rsp);
        checks++;
        if ({rd, irq_o} !== {32'h4, 1'b1}) begin
            errors++;
            $display("FAIL w1c_set_wins: got pend=%h irq=%b expected 4 1", rd, irq_o);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic rdy, rsp;
        bus_xfer(1'b0, 3'd2, 32'h1C, 32'd0, rd, rdy, rsp);
        checks++;
        if ({rdy, rsp, rd, hreadyout, hresp} !== {1'b0, 1'b1, 32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL err_read_phases: got err1=%b%b data=%h err2=%b%b expected 01 0 11",
                     rdy, rsp, rd, hreadyout, hresp);
        end
        tick(1);
        checks++;
        if ({hreadyout, hresp} !== 2'b10) begin
            errors++;
            $display("FAIL err_return_idle: got %b%b expected 10", hreadyout, hresp);
        end
        bus_xfer(1'b1, 3'd3, 32'h0C, 32'd0, rd, rdy, rsp);
        checks++;
        if ({rdy, rsp, hreadyout, hresp} !== 4'b0111) begin
            errors++;
            $display("FAIL err_hsize_phases: got %b%b %b%b expected 01 11", rdy, rsp, hreadyout, hresp);
        end
        // Address phase issued during ERR2.
        bus_xfer(1'b0, 3'd2, 32'h10, 32'd0, rd, rdy, rsp);
        checks++;
        if ({rdy, rsp, rd, led_o} !== {1'b1, 1'b0, 32'h4, 6'h3F}) begin
            errors++;
            $display("FAIL err_back_to_back: got rdy=%b resp=%b state=%h led=%h expected 1 0 4 3f",
                     rdy, rsp, rd, led_o);
        end
        bus_xfer(1'b1, 3'd4, 32'h18, 32'h1F, rd, rdy, rsp);
        tick(1);
        bus_xfer(1'b0, 3'd2, 32'h18, 32'd0, rd, rdy, rsp);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL err_no_update: got pend=%h expected 4", rd);
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0; btn_i = 5'h1F;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        m_led = '0; m_irqen = '0; m_pend = '0; m_state = '0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                logic [4:0] raw;
                raw = 5'($urandom);
                btn_i = raw;
                tick(DEB + 4);
                m_pend  = m_pend | (~raw & ~m_state);
                m_state = ~raw;
            end else begin
                logic [31:0] rd, wd, addr;
                logic [2:0] idx, sz;
                logic [1:0] lo;
                logic wr, rdy, rsp, err, lane0;
                idx  = 3'($urandom_range(0, 7));
                lo   = 2'($urandom_range(0, 3));
                sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                wr   = 1'($urandom);
                wd   = $urandom;
                addr = ($urandom & 32'hFFFF_FFE0) | {27'd0, idx, lo};
                err  = (sz > 3'd2) || (idx == 3'd7);
                bus_xfer(wr, sz, addr, wd, rd, rdy, rsp);
                checks++;
                if (err) begin
                    if ({rdy, rsp, rd} !== {1'b0, 1'b1, 32'd0}) begin
                        errors++;
                        $display("FAIL rnd_err[%0d]: got rdy=%b resp=%b data=%h expected 0 1 0",
                                 n, rdy, rsp, rd);
                    end
                end else if (!wr) begin
                    if ({rdy, rsp, rd} !== {1'b1, 1'b0, model_read(idx)}) begin
                        errors++;
                        $display("FAIL rnd_read[%0d] ofs=%h: got rdy=%b resp=%b data=%h expected 1 0 %h",
                                 n, {idx, 2'b00}, rdy, rsp, rd, model_read(idx));
                    end
                end else if ({rdy, rsp} !== 2'b10) begin
                    errors++;
                    $display("FAIL rnd_write[%0d]: got rdy=%b resp=%b expected 1 0", n, rdy, rsp);
                end
                lane0 = (sz == 3'd2) || (sz == 3'd1 && !lo[1]) || (sz == 3'd0 && lo == 2'd0);
                if (wr && !err && lane0) begin
                    case (idx)
                        3'd3:    m_led   = wd[5:0];
                        3'd5:    m_irqen = wd[4:0];
                        3'd6:    m_pend  = m_pend & ~wd[4:0];
                        default: ;
                    endcase
                end
                tick(1);
            end
            checks++;
            if ({led_o, irq_o} !== {m_led, |(m_pend & m_irqen)}) begin
                errors++;
                $display("FAIL rnd_outputs[%0d]: got led=%h irq=%b expected %h %b",
                         n, led_o, irq_o, m_led, |(m_pend & m_irqen));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r0, r1, rd;
        logic rdy, rsp;
        btn_i = 5'h1F;
        tick(DEB + 4);
        btn_i = 5'h1E;
        tick(DEB + 4);
        bus_xfer(1'b1, 3'd2, 32'h0C, 32'h2A, rd, rdy, rsp);
        bus_xfer(1'b1, 3'd2, 32'h14, 32'h1F, rd, rdy, rsp);
        tick(1);
        checks++;
        if ({led_o, irq_o} !== {6'h2A, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_setup: got led=%h irq=%b expected 2a 1", led_o, irq_o);
        end
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h1C;
        @(posedge clk); #1;
        bus_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hreadyout, hresp, hrdata, led_o, irq_o} !== {1'b1, 1'b0, 32'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_err1: got rdy=%b resp=%b data=%h led=%h irq=%b expected 1 0 0 0 0",
                     hreadyout, hresp, hrdata, led_o, irq_o);
        end
        tick(1);
        rst_n = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        // Counters restart from zero, so the held press needs the full latency again.
        tick(DEB);
        read2(32'h10, 32'h10, r0, r1);
        checks++;
        if ({r0, r1} !== {32'd0, 32'h1}) begin
            errors++;
            $display("FAIL reset_in_debounce: got edge9=%h edge10=%h expected 0 1", r0, r1);
        end
        read2(32'h14, 32'h0C, r0, r1);
        checks++;
        if ({r0, r1, irq_o} !== {32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_regs: got irqen=%h led=%h irq=%b expected 0 0 0", r0, r1, irq_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_id_regs();
        test_led();
        test_debounce();
        test_w1c();
        test_error();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
